// File: rtl/cpu_counters_if.sv
// CSR access bus between the execute stage (master) and the counter unit (slave).
// csr_rd/csr_wr are single-cycle strobes (never both high) qualified by csr_adr/csr_di;
// the slave has no back-pressure and answers with registered csr_do/csr_ok one edge later.
interface cpu_counters_if;
  logic        csr_rd;
  logic        csr_wr;
  logic [11:0] csr_adr;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        csr_ok;

  modport master (output csr_rd, csr_wr, csr_adr, csr_di, input csr_do, csr_ok);
  modport slave  (input csr_rd, csr_wr, csr_adr, csr_di, output csr_do, csr_ok);
endinterface

// File: rtl/cpu_counters.sv
// 64-bit cycle/time/instret counters with the user-level CSR read path
// and machine-mode writes to mcycle/minstret.
module cpu_counters #(
  parameter int unsigned F_CLK   = 12_000_000,
  parameter int unsigned TIME_HZ = 1_000_000
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           en,
  input  logic           retire,
  cpu_counters_if.slave  csr
);
  localparam int unsigned DIV = F_CLK / TIME_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  if ((TIME_HZ == 0) || (F_CLK < TIME_HZ) || ((F_CLK % TIME_HZ) != 0)) begin : g_bad_ratio
    $error("cpu_counters: F_CLK must be a non-zero integer multiple of TIME_HZ");
  end

  logic [63:0]   r_cycle;
  logic [63:0]   r_time;
  logic [63:0]   r_instret;
  logic [PW-1:0] r_pre;
  logic [31:0]   r_csr_do;
  logic          r_csr_ok;

  logic [31:0] w_rd_val;
  logic        w_rd_hit;
  logic        w_wr_cyc_lo;
  logic        w_wr_cyc_hi;
  logic        w_wr_ir_lo;
  logic        w_wr_ir_hi;
  logic        w_wr_hit;

  always_comb begin
    w_rd_val = 32'd0;
    w_rd_hit = 1'b1;
    case (csr.csr_adr)
      12'hC00, 12'hB00: w_rd_val = r_cycle[31:0];
      12'hC80, 12'hB80: w_rd_val = r_cycle[63:32];
      12'hC01:          w_rd_val = r_time[31:0];
      12'hC81:          w_rd_val = r_time[63:32];
      12'hC02, 12'hB02: w_rd_val = r_instret[31:0];
      12'hC82, 12'hB82: w_rd_val = r_instret[63:32];
      default:          w_rd_hit = 1'b0;
    endcase
  end

  // Only the machine-mode aliases are writable; user-level and time addresses fall through.
  assign w_wr_cyc_lo = csr.csr_wr && (csr.csr_adr == 12'hB00);
  assign w_wr_cyc_hi = csr.csr_wr && (csr.csr_adr == 12'hB80);
  assign w_wr_ir_lo  = csr.csr_wr && (csr.csr_adr == 12'hB02);
  assign w_wr_ir_hi  = csr.csr_wr && (csr.csr_adr == 12'hB82);
  assign w_wr_hit    = w_wr_cyc_lo || w_wr_cyc_hi || w_wr_ir_lo || w_wr_ir_hi;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cycle   <= 64'd0;
      r_time    <= 64'd0;
      r_instret <= 64'd0;
      r_pre     <= '0;
      r_csr_do  <= 32'd0;
      r_csr_ok  <= 1'b0;
    end else if (!en) begin
      r_cycle   <= 64'd0;
      r_time    <= 64'd0;
      r_instret <= 64'd0;
      r_pre     <= '0;
      r_csr_do  <= 32'd0;
      r_csr_ok  <= csr.csr_rd && w_rd_hit;
    end else begin
      if (w_wr_cyc_lo)      r_cycle <= {r_cycle[63:32], csr.csr_di};
      else if (w_wr_cyc_hi) r_cycle <= {csr.csr_di, r_cycle[31:0]};
      else                  r_cycle <= r_cycle + 64'd1;

      if (w_wr_ir_lo)       r_instret <= {r_instret[63:32], csr.csr_di};
      else if (w_wr_ir_hi)  r_instret <= {csr.csr_di, r_instret[31:0]};
      else if (retire)      r_instret <= r_instret + 64'd1;

      if (r_pre == PRE_MAX) begin
        r_pre  <= '0;
        r_time <= r_time + 64'd1;
      end else begin
        r_pre  <= r_pre + 1'b1;
      end

      if (csr.csr_rd) begin
        r_csr_do <= w_rd_val;
        r_csr_ok <= w_rd_hit;
      end else if (csr.csr_wr) begin
        r_csr_do <= 32'd0;
        r_csr_ok <= w_wr_hit;
      end
    end
  end

  assign csr.csr_do = r_csr_do;
  assign csr.csr_ok = r_csr_ok;
endmodule

// File: tb/tb_cpu_counters.sv
// Directed bench for cpu_counters with a 12:1 time prescaler (F_CLK=12, TIME_HZ=1).
module tb_cpu_counters;
  logic clk;
  logic n_reset;
  logic en;
  logic retire;
  int   n_tests;
  int   n_fail;

  cpu_counters_if bus();

  cpu_counters #(.F_CLK(12), .TIME_HZ(1)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (en),
    .retire  (retire),
    .csr     (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.csr_rd  = 1'b0;
    bus.csr_wr  = 1'b0;
    bus.csr_adr = 12'h000;
    bus.csr_di  = 32'd0;
  endtask

  task automatic csr_read(input logic [11:0] adr);
    bus.csr_rd  = 1'b1;
    bus.csr_wr  = 1'b0;
    bus.csr_adr = adr;
    cycle();
    idle();
  endtask

  task automatic csr_write(input logic [11:0] adr, input logic [31:0] data);
    bus.csr_rd  = 1'b0;
    bus.csr_wr  = 1'b1;
    bus.csr_adr = adr;
    bus.csr_di  = data;
    cycle();
    idle();
  endtask

  // one edge with en low clears everything, then counting resumes
  task automatic restart();
    en = 1'b0;
    cycle();
    en = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] exp_do, input logic exp_ok);
    n_tests++;
    if (bus.csr_do !== exp_do || bus.csr_ok !== exp_ok) begin
      n_fail++;
      $display("FAIL %s: got do=%08h ok=%0b, expected do=%08h ok=%0b",
               name, bus.csr_do, bus.csr_ok, exp_do, exp_ok);
    end
  endtask

  task automatic test_reset();
    restart();
    repeat (5) cycle();
    csr_read(12'hC00);
    check("pre_reset_read", 32'd5, 1'b1);
    #2;
    n_reset = 1'b0;
    #1;
    check("async_reset", 32'd0, 1'b0);
    @(negedge clk);
    n_reset = 1'b1;
    #1;
    csr_read(12'hC00);
    check("cycle_after_reset", 32'd0, 1'b1);
  endtask

  task automatic test_cycle();
    restart();
    repeat (10) cycle();
    csr_read(12'hC00);
    check("cycle_10", 32'd10, 1'b1);
    csr_read(12'hB80);
    check("mcycleh_0", 32'd0, 1'b1);
  endtask

  task automatic test_instret();
    restart();
    for (int i = 0; i < 3; i++) begin
      retire = 1'b1;
      cycle();
      retire = 1'b0;
      cycle();
    end
    retire = 1'b1;
    csr_read(12'hC02);
    retire = 1'b0;
    check("instret_pre_inc", 32'd3, 1'b1);
    csr_read(12'hB02);
    check("instret_reread", 32'd4, 1'b1);
  endtask

  task automatic test_write_wrap();
    restart();
    csr_write(12'hB80, 32'hFFFF_FFFF);
    check("wr_hi_ack", 32'd0, 1'b1);
    csr_write(12'hB00, 32'hFFFF_FFFE);
    csr_read(12'hC00);
    check("cycle_lo_written", 32'hFFFF_FFFE, 1'b1);
    cycle();
    csr_read(12'hC80);
    check("cycle_hi_wrapped", 32'h0000_0000, 1'b1);
  endtask

  task automatic test_instret_write();
    restart();
    csr_write(12'hB82, 32'd7);
    check("wr_ir_hi_ack", 32'd0, 1'b1);
    csr_read(12'hC02);
    check("ir_lo_kept", 32'd0, 1'b1);
    retire = 1'b1;
    csr_write(12'hB02, 32'd100);
    retire = 1'b0;
    csr_read(12'hC02);
    check("ir_write_beats_retire", 32'd100, 1'b1);
    csr_read(12'hC82);
    check("ir_hi_written", 32'd7, 1'b1);
  endtask

  task automatic test_time();
    restart();
    repeat (36) cycle();
    csr_read(12'hC01);
    check("time_lo_3", 32'd3, 1'b1);
    csr_read(12'hC81);
    check("time_hi_0", 32'd0, 1'b1);
    csr_write(12'hC01, 32'd50);
    check("time_write_ignored_ok", 32'd0, 1'b0);
  endtask

  task automatic test_illegal_and_clear();
    restart();
    csr_read(12'hC00);
    check("legal_before_illegal", 32'd0, 1'b1);
    csr_read(12'h300);
    check("unmapped_read", 32'd0, 1'b0);
    csr_write(12'hC00, 32'd5);
    check("ro_write_ok", 32'd0, 1'b0);
    csr_read(12'hC00);
    check("ro_write_ignored", 32'd3, 1'b1);
    en = 1'b0;
    csr_read(12'hC00);
    check("read_while_disabled", 32'd0, 1'b1);
    en = 1'b1;
    csr_read(12'hC00);
    check("cleared_by_en_low", 32'd0, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_reset = 1'b0;
    en      = 1'b0;
    retire  = 1'b0;
    idle();
    #1;
    check("reset_state", 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;

    test_reset();
    test_cycle();
    test_instret();
    test_write_wrap();
    test_instret_write();
    test_time();
    test_illegal_and_clear();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
